// File: rtl/bus_pkg.sv
// Shared definitions for the databus arbiter: FSM encoding, default widths and
// the round-robin index search used by rr_pick.
package bus_pkg;

  localparam int MAX_REQ    = 4;
  localparam int IDX_W      = 2;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // First set bit of req searching from last+1 upward, wrapping modulo n.
  // Returns last unchanged when req is empty; callers gate on |req.
  function automatic logic [IDX_W-1:0] rr_next_idx(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   last,
    input int                 n
  );
    logic found;
    int   j;
    rr_next_idx = last;
    found       = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = (int'(last) + k) % n;
      if (k <= n && !found && req[j[IDX_W-1:0]]) begin
        rr_next_idx = IDX_W'(j);
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority rotator: one-hot choice plus its index,
// starting the search just after the previous winner.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic [MAX_REQ-1:0] req_ext;

  assign req_ext = MAX_REQ'(req);

  always_comb begin
    pick_idx = rr_next_idx(req_ext, last, N_REQ);
    pick     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick[i] = (|req) && (int'(pick_idx) == i);
    end
  end

endmodule

// File: rtl/databus_arbiter.sv
// Round-robin owner of the shared memory-mapped bus with a dead turnaround
// cycle between owners and a bounded hold time under contention.
module databus_arbiter
  import bus_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_rd,
  input  logic [N_REQ-1:0]         req_wr,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [DATA_W-1:0]        bus_wdata,
  output logic                     bus_rd,
  output logic                     bus_wr,
  output logic [N_REQ-1:0]         rd_valid,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  // Handshake: a requester raises req and holds it level for its whole
  // ownership. gnt[i] (registered, one-hot) is the "ready": strobes, address
  // and data from requester i are taken only in cycles where gnt[i] is high
  // and reach the bus one cycle later. Dropping req ends ownership; gnt then
  // falls on the next edge and one TURN cycle keeps the bus undriven.

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_GRANT = 2'(GRANT);
  localparam logic [1:0] ST_TURN  = 2'(TURN);

  localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_n_req
    $error("databus_arbiter: N_REQ must be 2..4");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("databus_arbiter: MAX_HOLD must be at least 2");
  end

  logic [1:0]        state;
  logic [IDX_W-1:0]  last;
  logic [HOLD_W-1:0] hold;

  logic [N_REQ-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;

  logic              own_req;
  logic              own_rd;
  logic              own_wr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              others;
  logic              rel_now;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req      (req),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Only the granted requester's lanes are visible; everyone else is ignored.
  always_comb begin
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        own_rd    = req_rd[i];
        own_wr    = req_wr[i];
        own_addr  = req_addr[i*ADDR_W +: ADDR_W];
        own_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign own_req = |(req & gnt);
  assign others  = |(req & ~gnt);
  // A drop wins over preemption; both take the same TURN path.
  assign rel_now = !own_req || (others && (hold == HOLD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      last      <= IDX_W'(N_REQ - 1);
      hold      <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      rd_valid  <= '0;
    end else begin
      rd_valid <= gnt & {N_REQ{bus_rd}};
      case (state)
        ST_IDLE: begin
          bus_rd <= 1'b0;
          bus_wr <= 1'b0;
          if (|req) begin
            gnt   <= pick;
            last  <= pick_idx;
            hold  <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rel_now) begin
            gnt    <= '0;
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
            hold   <= '0;
            state  <= ST_TURN;
          end else begin
            bus_addr  <= own_addr;
            bus_wdata <= own_wdata;
            bus_wr    <= own_wr;
            // Read plus write together is illegal; the write is passed alone.
            bus_rd    <= own_rd & ~own_wr;
            if (!others) begin
              hold <= '0;
            end else if (hold != HOLD_LAST) begin
              hold <= hold + 1'b1;
            end
          end
        end
        ST_TURN: begin
          gnt    <= '0;
          bus_rd <= 1'b0;
          bus_wr <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          gnt    <= '0;
          bus_rd <= 1'b0;
          bus_wr <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state == ST_GRANT);
  assign dbg_state = state;

endmodule

// File: tb/tb_databus_arbiter.sv
// Directed bench for databus_arbiter: a vector table for single-cycle
// behaviour plus hand-written fairness and preemption sequences.
module tb_databus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NV = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  req_rd;
  logic [N-1:0]  req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_rd;
  logic          bus_wr;
  logic [N-1:0]  rd_valid;
  logic          busy;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  databus_arbiter #(
    .N_REQ    (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_HOLD (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  e_gnt;
    bit          e_rd;
    bit          e_wr;
    logic [3:0]  e_rdv;
    bit          e_busy;
    bit          chk_bus;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
  } vec_t;

  vec_t vecs[NV];

  function automatic logic [63:0] pk(input logic [15:0] a3, input logic [15:0] a2,
                                     input logic [15:0] a1, input logic [15:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input bit r, input logic [3:0] rq, input logic [3:0] rd,
                              input logic [3:0] wr, input logic [63:0] a, input logic [63:0] d,
                              input logic [3:0] eg, input bit erd, input bit ewr,
                              input logic [3:0] ev, input bit eb, input bit cb,
                              input logic [15:0] ea, input logic [15:0] ed);
    vec_t v;
    v.rst = r; v.req = rq; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
    v.e_gnt = eg; v.e_rd = erd; v.e_wr = ewr; v.e_rdv = ev; v.e_busy = eb;
    v.chk_bus = cb; v.e_addr = ea; v.e_wdata = ed;
    return v;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input logic [3:0] rq, input logic [3:0] rd,
                       input logic [3:0] wr, input logic [63:0] a, input logic [63:0] d);
    rst = r; req = rq; req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin
    int cyc;
    int gap;
    logic [3:0] own;

    // Reset state
    drive(1'b1, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step();
    step();
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_bus_addr", bus_addr, 16'h0);
    chk("rst_bus_wdata", bus_wdata, 16'h0);
    chk("rst_bus_rd", bus_rd, 1'b0);
    chk("rst_bus_wr", bus_wr, 1'b0);
    chk("rst_rd_valid", rd_valid, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 2'd0);

    // Single requester read, write passthrough, TURN arrival, illegal strobe,
    // reset mid-write. Expected values are the outputs after the row's edge.
    vecs[0]  = mk(0, 4'h1, 4'h1, 4'h0, pk(0, 0, 0, 16'h1004), 64'h0, 4'h1, 0, 0, 4'h0, 1, 1, 16'h0, 16'h0);
    vecs[1]  = mk(0, 4'h1, 4'h1, 4'h0, pk(0, 0, 0, 16'h1004), 64'h0, 4'h1, 1, 0, 4'h0, 1, 1, 16'h1004, 16'h0);
    vecs[2]  = mk(0, 4'h1, 4'h1, 4'h0, pk(0, 0, 0, 16'h1004), 64'h0, 4'h1, 1, 0, 4'h1, 1, 1, 16'h1004, 16'h0);
    vecs[3]  = mk(0, 4'h1, 4'h1, 4'h0, pk(0, 0, 0, 16'h1004), 64'h0, 4'h1, 1, 0, 4'h1, 1, 1, 16'h1004, 16'h0);
    vecs[4]  = mk(0, 4'h1, 4'h1, 4'h0, pk(0, 0, 0, 16'h1004), 64'h0, 4'h1, 1, 0, 4'h1, 1, 1, 16'h1004, 16'h0);
    vecs[5]  = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h1, 0, 0, 16'h0, 16'h0);
    vecs[6]  = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);
    vecs[7]  = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);
    vecs[8]  = mk(0, 4'h8, 4'h0, 4'h8, pk(16'h2000, 0, 0, 16'h1111), pk(16'hBEEF, 0, 0, 16'h2222),
                  4'h8, 0, 0, 4'h0, 1, 0, 16'h0, 16'h0);
    vecs[9]  = mk(0, 4'hA, 4'h3, 4'h9, pk(16'h2000, 0, 16'h3333, 16'h1111), pk(16'hBEEF, 0, 16'h7777, 16'h2222),
                  4'h8, 0, 1, 4'h0, 1, 1, 16'h2000, 16'hBEEF);
    vecs[10] = mk(0, 4'h8, 4'h0, 4'h8, pk(16'h2000, 0, 0, 0), pk(16'hBEEF, 0, 0, 0),
                  4'h8, 0, 1, 4'h0, 1, 1, 16'h2000, 16'hBEEF);
    vecs[11] = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);
    vecs[12] = mk(0, 4'h2, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);
    vecs[13] = mk(0, 4'h2, 4'h0, 4'h0, 64'h0, 64'h0, 4'h2, 0, 0, 4'h0, 1, 0, 16'h0, 16'h0);
    vecs[14] = mk(0, 4'h2, 4'h2, 4'h2, pk(0, 0, 16'h4444, 0), pk(0, 0, 16'h5555, 0),
                  4'h2, 0, 1, 4'h0, 1, 1, 16'h4444, 16'h5555);
    vecs[15] = mk(0, 4'h2, 4'h2, 4'h2, pk(0, 0, 16'h4444, 0), pk(0, 0, 16'h5555, 0),
                  4'h2, 0, 1, 4'h0, 1, 1, 16'h4444, 16'h5555);
    vecs[16] = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);
    vecs[17] = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);
    vecs[18] = mk(0, 4'h1, 4'h0, 4'h1, pk(0, 0, 0, 16'h0A0A), pk(0, 0, 0, 16'h1234),
                  4'h1, 0, 0, 4'h0, 1, 0, 16'h0, 16'h0);
    vecs[19] = mk(0, 4'h1, 4'h0, 4'h1, pk(0, 0, 0, 16'h0A0A), pk(0, 0, 0, 16'h1234),
                  4'h1, 0, 1, 4'h0, 1, 1, 16'h0A0A, 16'h1234);
    vecs[20] = mk(1, 4'h1, 4'h0, 4'h1, pk(0, 0, 0, 16'h0A0A), pk(0, 0, 0, 16'h1234),
                  4'h0, 0, 0, 4'h0, 0, 1, 16'h0, 16'h0);
    vecs[21] = mk(0, 4'hF, 4'h0, 4'h0, 64'h0, 64'h0, 4'h1, 0, 0, 4'h0, 1, 1, 16'h0, 16'h0);
    vecs[22] = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);
    vecs[23] = mk(0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 4'h0, 0, 0, 4'h0, 0, 0, 16'h0, 16'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      step();
      chk($sformatf("v%0d_gnt", i), gnt, vecs[i].e_gnt);
      chk($sformatf("v%0d_bus_rd", i), bus_rd, vecs[i].e_rd);
      chk($sformatf("v%0d_bus_wr", i), bus_wr, vecs[i].e_wr);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].e_rdv);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].chk_bus) begin
        chk($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_bus_wdata", i), bus_wdata, vecs[i].e_wdata);
      end
    end

    // Fairness: all four request, each owner drops after 3 cycles and reasserts.
    drive(1'b1, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step();
    drive(1'b0, 4'hF, 4'h0, 4'h0, 64'h0, 64'h0);
    step();
    for (int r = 0; r < 8; r++) begin
      own = 4'(1 << (r % 4));
      chk($sformatf("fair%0d_gnt", r), gnt, own);
      step();
      chk($sformatf("fair%0d_gnt_hold1", r), gnt, own);
      step();
      chk($sformatf("fair%0d_gnt_hold2", r), gnt, own);
      req = 4'hF & ~own;
      step();
      chk($sformatf("fair%0d_turn_gnt", r), gnt, 4'h0);
      chk($sformatf("fair%0d_turn_state", r), dbg_state, 2'd2);
      req = 4'hF;
      gap = 1;
      step();
      while (gnt == 4'h0 && gap < 10) begin
        gap++;
        step();
      end
      chk($sformatf("fair%0d_gap", r), gap, 2);
    end

    // Preemption: owner 1 reads forever, requester 2 arrives at cycle 5.
    drive(1'b1, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step();
    drive(1'b0, 4'h2, 4'h2, 4'h0, pk(0, 0, 16'h1500, 0), 64'h0);
    step();
    cyc = 1;
    chk("pre_gnt1", gnt, 4'h2);
    while (cyc < 5) begin
      step();
      cyc++;
    end
    req = 4'h6;
    while (gnt == 4'h2 && cyc < 60) begin
      step();
      cyc++;
    end
    chk("pre_release_cycle", cyc, 21);
    chk("pre_turn_gnt", gnt, 4'h0);
    chk("pre_turn_bus_rd", bus_rd, 1'b0);
    chk("pre_turn_bus_wr", bus_wr, 1'b0);
    chk("pre_turn_busy", busy, 1'b0);
    chk("pre_turn_rd_valid", rd_valid, 4'h2);
    step();
    chk("pre_idle_gnt", gnt, 4'h0);
    chk("pre_idle_bus_rd", bus_rd, 1'b0);
    chk("pre_idle_rd_valid", rd_valid, 4'h0);
    step();
    chk("pre_next_gnt", gnt, 4'h4);
    req = 4'h2;
    step();
    chk("pre_turn2_gnt", gnt, 4'h0);
    step();
    step();
    chk("pre_rejoin_gnt", gnt, 4'h2);

    drive(1'b0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
